// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO frame deserializer.
// Holds the output-buffer state enum, the bit-counter width helper and the even-parity function.
package sipo_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Parity helper operates on a fixed-width, zero-extended vector; words wider than this are not supported.
    localparam int unsigned PARITY_MAX_W = 256;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// One-entry holding register between the deserializer and a word consumer, with sticky overrun.
// Handshake: a word transfers on a falling edge where state==BUF_FULL (valid) and ready are both 1;
// valid never depends on ready, and a completed word arriving while FULL without ready is dropped.
module sipo_out_buffer
    import sipo_pkg::*;
#(
    parameter int DW = 33
) (
    input  logic          Clk_In,
    input  logic          Reset_In,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          ready,
    input  logic          clear_overrun,
    output logic [DW-1:0] data_out,
    output logic          overrun,
    output buf_state_t    state
);

    buf_state_t state_d;
    logic       load_en;
    logic       drop;

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state    <= BUF_EMPTY;
            data_out <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_d;
            if (load_en) begin
                data_out <= load_data;
            end
            // Setting wins over a coincident clear.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state;
        load_en = 1'b0;
        drop    = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (load) begin
                    state_d = BUF_FULL;
                    load_en = 1'b1;
                end
            end
            BUF_FULL: begin
                if (load) begin
                    // Consumer takes the old word on the same edge the new one lands: no bubble.
                    if (ready) begin
                        load_en = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Serial-in/parallel-out deserializer with bit counting, frame sync and a valid/ready output buffer.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame and report mismatches.
module sipo_frame_deserializer
    import sipo_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Enable_In,
    input  logic             Shift_Data_Signal_In,
    input  logic             Serial_Data_In,
    input  logic             Frame_Sync_In,
    input  logic             Clear_Overrun_In,
    output logic [WIDTH-1:0] Parallel_Data_Out,
    output logic             Data_Valid_Out,
    input  logic             Data_Ready_In,
    output logic             Overrun_Out,
    output logic             Parity_Error_Out,
    output logic [CNT_W-1:0] Bit_Count_Out
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
    localparam int BUF_W     = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
    localparam int BUF_W     = WIDTH;
`endif

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_base;
    logic [WIDTH-1:0] sr_shifted;
    logic [CNT_W-1:0] count_q;
    logic             do_shift;
    logic             do_sync;
    logic             data_bit_phase;
    logic             complete;
    logic [BUF_W-1:0] load_data;
    logic [BUF_W-1:0] buf_data;
    buf_state_t       buf_state;

    always_comb begin
        do_shift       = Enable_In & Shift_Data_Signal_In;
        do_sync        = Enable_In & Frame_Sync_In;
        sr_base        = do_sync ? '0 : sr_q;
        sr_shifted     = MSB_FIRST ? {sr_base[WIDTH-2:0], Serial_Data_In}
                                   : {Serial_Data_In, sr_base[WIDTH-1:1]};
        // The trailing parity bit (count==WIDTH) is not part of the data word.
        data_bit_phase = do_sync || (count_q < CNT_W'(WIDTH));
        complete       = do_shift && !do_sync && (count_q == CNT_W'(FRAME_LEN - 1));
    end

`ifdef SIPO_PARITY_EN
    assign load_data = {even_parity(PARITY_MAX_W'(sr_q)) ^ Serial_Data_In, sr_q};
`else
    assign load_data = sr_shifted;
`endif

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            sr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_shift && data_bit_phase) begin
                sr_q <= sr_shifted;
            end else if (do_sync) begin
                sr_q <= '0;
            end
            // A bit shifted on the sync edge is bit 0 of the new frame.
            if (do_sync) begin
                count_q <= do_shift ? CNT_W'(1) : '0;
            end else if (do_shift) begin
                count_q <= complete ? '0 : count_q + CNT_W'(1);
            end
        end
    end

    sipo_out_buffer #(
        .DW(BUF_W)
    ) u_out_buffer (
        .Clk_In        (Clk_In),
        .Reset_In      (Reset_In),
        .load          (complete),
        .load_data     (load_data),
        .ready         (Data_Ready_In),
        .clear_overrun (Clear_Overrun_In),
        .data_out      (buf_data),
        .overrun       (Overrun_Out),
        .state         (buf_state)
    );

    assign Parallel_Data_Out = buf_data[WIDTH-1:0];
    assign Data_Valid_Out    = (buf_state == BUF_FULL);
    assign Bit_Count_Out     = count_q;

`ifdef SIPO_PARITY_EN
    assign Parity_Error_Out = buf_data[WIDTH];
`else
    assign Parity_Error_Out = 1'b0;
`endif

endmodule
